// File: rtl/line_fill_responder.sv
//------------------------------------------------------------------------------
// line_fill_responder: fetches a 16-byte cache line as 16 byte reads and returns
// it as one 128-bit little-endian word. Optional macro: LINE_FILL_PREFETCH_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module line_fill_responder #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              mem_read,
   input  logic [ADDR_W-1:0] mem_addr,
   output logic [127:0]      mem_data_o,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_din
);

   localparam int HI_W = ADDR_W - 4;

`ifdef LINE_FILL_PREFETCH_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DONE  = 3'd2,
      S_COOL  = 3'd3,
      S_DRAIN = 3'd4,
      S_PF    = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DONE  = 3'd2,
      S_COOL  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;
`endif

   state_t            r_state;
   logic [HI_W-1:0]   r_base_hi;
   logic [4:0]        r_issue;
   logic [4:0]        r_cap;
   logic [3:0]        r_ram_idx;
   logic [127:0]      r_line;
   logic              r_pv   [RAM_LAT];
   logic [3:0]        r_pidx [RAM_LAT];

   logic [HI_W-1:0]   w_req_hi;
   logic [HI_W-1:0]   w_start_hi;
   logic              w_start;
   logic              w_engine;
   logic              w_cap;
   logic              w_last;
   logic              w_pipe_busy;
   logic [127:0]      w_line_next;
   logic              w_unused;

`ifdef LINE_FILL_PREFETCH_EN
   logic              r_pf_valid;
   logic              r_pf_pend;
   logic [HI_W-1:0]   r_pf_hi;
   logic [HI_W-1:0]   r_pf_next_hi;
   logic [127:0]      r_pf_line;
   logic              w_pf_hit;
`endif

   assign w_req_hi = mem_addr[ADDR_W-1:4];
   assign w_unused = ^mem_addr[3:0];

`ifdef LINE_FILL_PREFETCH_EN
   assign w_pf_hit   = r_pf_valid && (w_req_hi == r_pf_hi);
   assign w_start    = (mem_read && !w_pf_hit) || (!mem_read && r_pf_pend);
   assign w_start_hi = mem_read ? w_req_hi : r_pf_next_hi;
   assign w_engine   = (r_state == S_FETCH) || (r_state == S_PF);
`else
   assign w_start    = mem_read;
   assign w_start_hi = w_req_hi;
   assign w_engine   = (r_state == S_FETCH);
`endif

   // The oldest pipe slot is the tag of the byte currently on ram_din.
   assign w_cap  = w_engine && r_pv[RAM_LAT-1];
   assign w_last = w_cap && (r_cap == 5'd15);

   always_comb begin
      w_pipe_busy = 1'b0;
      for (int j = 0; j < RAM_LAT; j++) begin
         w_pipe_busy = w_pipe_busy | r_pv[j];
      end
   end

   always_comb begin
      w_line_next = r_line;
      if (w_cap) begin
         w_line_next[{r_pidx[RAM_LAT-1], 3'b000} +: 8] = ram_din;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         mem_data_o <= '0;
         mem_busy   <= 1'b0;
         mem_done   <= 1'b0;
         ram_rd_en  <= 1'b0;
         ram_addr   <= '0;
         r_base_hi  <= '0;
         r_issue    <= '0;
         r_cap      <= '0;
         r_ram_idx  <= '0;
         r_line     <= '0;
         for (int j = 0; j < RAM_LAT; j++) begin
            r_pv[j]   <= 1'b0;
            r_pidx[j] <= '0;
         end
`ifdef LINE_FILL_PREFETCH_EN
         r_pf_valid   <= 1'b0;
         r_pf_pend    <= 1'b0;
         r_pf_hi      <= '0;
         r_pf_next_hi <= '0;
         r_pf_line    <= '0;
`endif
      end else begin
         mem_done  <= 1'b0;
         r_pv[0]   <= ram_rd_en;
         r_pidx[0] <= r_ram_idx;
         for (int j = 1; j < RAM_LAT; j++) begin
            r_pv[j]   <= r_pv[j-1];
            r_pidx[j] <= r_pidx[j-1];
         end

         // Issue/capture engine shared by demand and background fills.
         if (w_engine) begin
            r_line <= w_line_next;
            if (w_cap) begin
               r_cap <= r_cap + 5'd1;
            end
            if (!r_issue[4]) begin
               ram_rd_en <= 1'b1;
               ram_addr  <= {r_base_hi, r_issue[3:0]};
               r_ram_idx <= r_issue[3:0];
               r_issue   <= r_issue + 5'd1;
            end else begin
               ram_rd_en <= 1'b0;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_base_hi <= w_start_hi;
                  r_issue   <= 5'd1;
                  r_cap     <= 5'd0;
                  r_ram_idx <= 4'd0;
                  ram_rd_en <= 1'b1;
                  ram_addr  <= {w_start_hi, 4'h0};
               end
`ifdef LINE_FILL_PREFETCH_EN
               if (mem_read && w_pf_hit) begin
                  r_state      <= S_DONE;
                  mem_done     <= 1'b1;
                  mem_data_o   <= r_pf_line;
                  r_pf_valid   <= 1'b0;
                  r_pf_pend    <= 1'b1;
                  r_pf_next_hi <= w_req_hi + HI_W'(1);
               end else if (mem_read) begin
                  r_state    <= S_FETCH;
                  mem_busy   <= 1'b1;
                  r_pf_valid <= 1'b0;
                  r_pf_pend  <= 1'b0;
               end else if (r_pf_pend) begin
                  r_state    <= S_PF;
                  r_pf_hi    <= r_pf_next_hi;
                  r_pf_valid <= 1'b0;
                  r_pf_pend  <= 1'b0;
               end
`else
               if (mem_read) begin
                  r_state  <= S_FETCH;
                  mem_busy <= 1'b1;
               end
`endif
            end

            S_FETCH: begin
               if (!mem_read) begin
                  r_state   <= S_DRAIN;
                  ram_rd_en <= 1'b0;
               end else if (w_last) begin
                  r_state    <= S_DONE;
                  mem_done   <= 1'b1;
                  mem_busy   <= 1'b0;
                  mem_data_o <= w_line_next;
`ifdef LINE_FILL_PREFETCH_EN
                  r_pf_pend    <= 1'b1;
                  r_pf_next_hi <= r_base_hi + HI_W'(1);
`endif
               end
            end

`ifdef LINE_FILL_PREFETCH_EN
            S_PF: begin
               if (mem_read && (w_req_hi != r_base_hi)) begin
                  r_state   <= S_DRAIN;
                  ram_rd_en <= 1'b0;
                  mem_busy  <= 1'b1;
               end else if (w_last && mem_read) begin
                  r_state      <= S_DONE;
                  mem_done     <= 1'b1;
                  mem_data_o   <= w_line_next;
                  r_pf_pend    <= 1'b1;
                  r_pf_next_hi <= r_base_hi + HI_W'(1);
               end else if (w_last) begin
                  r_state    <= S_IDLE;
                  r_pf_line  <= w_line_next;
                  r_pf_valid <= 1'b1;
               end else if (mem_read) begin
                  r_state  <= S_FETCH;
                  mem_busy <= 1'b1;
               end
            end
`endif

            S_DONE: r_state <= S_COOL;

            S_COOL: r_state <= S_IDLE;

            // Bytes still in flight are dropped so they never reach a later line.
            S_DRAIN: begin
               ram_rd_en <= 1'b0;
               if (!w_pipe_busy) begin
                  r_state  <= S_IDLE;
                  mem_busy <= 1'b0;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
